// File: rtl/de2_115_qsys_cpu_0_oci_dct_ctrl.sv
// Trace-atom packer: collects 2-bit atoms into 15-slot frames and hands each
// frame to the trace RAM with a valid/ready write port and a running address.
module de2_115_qsys_cpu_0_oci_dct_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              trc_clr,
  input  logic              wrap_en,
  input  logic              atom_valid,
  input  logic [1:0]        atom,
  input  logic              flush,
  input  logic              tw_ready,
  output logic              tw_valid,
  output logic [35:0]       tw_data,
  output logic [ADDR_W-1:0] tw_addr,
  output logic [29:0]       dct_buffer,
  output logic [3:0]        dct_count,
  output logic              trc_full,
  output logic              trc_wrap,
  output logic              atom_drop
);

  typedef enum logic [1:0] {EMPTY, FILL, PEND, HALT} state_t;

  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  state_t      state;
  state_t      state_n;
  logic        flush_pend;
  logic        handshake;
  logic        going_full;
  logic        xfer_req;
  logic        do_xfer;
  logic        atom_in;
  logic        accept;
  logic        drop;
  logic        valid_n;
  logic [3:0]  slot;
  logic [3:0]  cnt_n;
  logic [29:0] buf_n;

  // The pending-write flag and the halt flag are decodes of the state register.
  assign tw_valid = (state == PEND);
  assign trc_full = (state == HALT);

  assign handshake  = tw_valid & tw_ready;
  // The final write before halting must not launch another frame in the same cycle.
  assign going_full = handshake & (tw_addr == ADDR_TOP) & ~wrap_en;
  assign xfer_req   = (dct_count == 4'd15) | ((flush | flush_pend) & (dct_count != 4'd0));
  assign do_xfer    = xfer_req & ~trc_full & (~tw_valid | tw_ready) & ~going_full;
  assign atom_in    = atom_valid & trc_on & ~trc_full;
  assign accept     = atom_in & ((dct_count != 4'd15) | do_xfer);
  assign drop       = atom_in & ~accept;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot  = do_xfer ? 4'd0 : dct_count;
    buf_n = do_xfer ? 30'd0 : dct_buffer;
    cnt_n = slot;
    if (accept) begin
      buf_n[{slot, 1'b0} +: 2] = atom;
      cnt_n = slot + 4'd1;
    end
  end

  always_comb begin
    valid_n = tw_valid;
    if (do_xfer)        valid_n = 1'b1;
    else if (handshake) valid_n = 1'b0;

    state_n = EMPTY;
    if (going_full || trc_full) state_n = HALT;
    else if (valid_n)           state_n = PEND;
    else if (cnt_n != 4'd0)     state_n = FILL;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      tw_data    <= '0;
      tw_addr    <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      trc_wrap   <= 1'b0;
      atom_drop  <= 1'b0;
      flush_pend <= 1'b0;
    end else if (trc_clr) begin
      state      <= EMPTY;
      tw_addr    <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      trc_wrap   <= 1'b0;
      atom_drop  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      dct_buffer <= buf_n;
      dct_count  <= cnt_n;
      if (do_xfer)
        tw_data <= {2'b10, dct_count, dct_buffer};
      // Incrementing past the top address rolls to 0, which is also the halt address.
      if (handshake)
        tw_addr <= tw_addr + 1'b1;
      if (handshake && (tw_addr == ADDR_TOP) && wrap_en)
        trc_wrap <= 1'b1;
      if (drop)
        atom_drop <= 1'b1;
      if (do_xfer)
        flush_pend <= 1'b0;
      else if (flush && (dct_count != 4'd0))
        flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de2_115_qsys_cpu_0_oci_dct_ctrl.sv
// Directed bench for the trace-atom packer: framing, flush, back-pressure,
// full/wrap addressing, clear and asynchronous reset.
module tb_de2_115_qsys_cpu_0_oci_dct_ctrl;

  localparam int ADDR_W = 7;

  logic              clk;
  logic              reset_n;
  logic              trc_on;
  logic              trc_clr;
  logic              wrap_en;
  logic              atom_valid;
  logic [1:0]        atom;
  logic              flush;
  logic              tw_ready;
  logic              tw_valid;
  logic [35:0]       tw_data;
  logic [ADDR_W-1:0] tw_addr;
  logic [29:0]       dct_buffer;
  logic [3:0]        dct_count;
  logic              trc_full;
  logic              trc_wrap;
  logic              atom_drop;

  int checks;
  int failures;
  int hs;
  int cyc;

  de2_115_qsys_cpu_0_oci_dct_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .trc_clr(trc_clr),
    .wrap_en(wrap_en), .atom_valid(atom_valid), .atom(atom), .flush(flush),
    .tw_ready(tw_ready), .tw_valid(tw_valid), .tw_data(tw_data),
    .tw_addr(tw_addr), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .trc_full(trc_full), .trc_wrap(trc_wrap), .atom_drop(atom_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    trc_clr = 1'b1;
    tick();
    trc_clr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; trc_on = 1'b0; trc_clr = 1'b0; wrap_en = 1'b0;
    atom_valid = 1'b0; atom = 2'b00; flush = 1'b0; tw_ready = 1'b0;
    #12;
    check("rst_valid", 64'(tw_valid), 64'd0);
    check("rst_data",  64'(tw_data), 64'd0);
    check("rst_count", 64'(dct_count), 64'd0);
    check("rst_flags", 64'({trc_full, trc_wrap, atom_drop}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Fifteen 01 atoms fill one frame which transfers and retires at address 0.
    trc_on = 1'b1; tw_ready = 1'b1; atom = 2'b01; atom_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("full15_count", 64'(dct_count), 64'd15);
    check("full15_buf", 64'(dct_buffer), 64'h1555_5555);
    check("full15_valid", 64'(tw_valid), 64'd0);
    atom_valid = 1'b0;
    tick();
    check("f15_valid", 64'(tw_valid), 64'd1);
    check("f15_data", 64'(tw_data), 64'({2'b10, 4'd15, 30'h1555_5555}));
    check("f15_addr", 64'(tw_addr), 64'd0);
    check("f15_count", 64'(dct_count), 64'd0);
    tick();
    check("f15_hs_valid", 64'(tw_valid), 64'd0);
    check("f15_hs_addr", 64'(tw_addr), 64'd1);

    // Partial frame by flush, then a flush of an empty buffer does nothing.
    clear();
    atom = 2'b11; atom_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    atom_valid = 1'b0;
    check("p3_buf", 64'(dct_buffer), 64'h3F);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("p3_valid", 64'(tw_valid), 64'd1);
    check("p3_data", 64'(tw_data), 64'({2'b10, 4'd3, 30'h3F}));
    check("p3_count", 64'(dct_count), 64'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush0_valid", 64'(tw_valid), 64'd0);
    check("flush0_addr", 64'(tw_addr), 64'd1);

    // Back-pressure: first frame held, second fills, atom 31 is dropped.
    clear();
    tw_ready = 1'b0; atom = 2'b10; atom_valid = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("bp_count30", 64'(dct_count), 64'd15);
    check("bp_drop30", 64'(atom_drop), 64'd0);
    check("bp_data", 64'(tw_data), 64'({2'b10, 4'd15, 30'h2AAA_AAAA}));
    tick();
    atom_valid = 1'b0;
    check("bp_drop31", 64'(atom_drop), 64'd1);
    check("bp_count31", 64'(dct_count), 64'd15);
    check("bp_valid", 64'(tw_valid), 64'd1);
    check("bp_addr", 64'(tw_addr), 64'd0);
    tw_ready = 1'b1;
    tick();
    check("bp_b2b_valid", 64'(tw_valid), 64'd1);
    check("bp_b2b_addr", 64'(tw_addr), 64'd1);
    check("bp_b2b_count", 64'(dct_count), 64'd0);

    // Stop-when-full: 128 one-atom frames, then halt at address 0.
    clear();
    wrap_en = 1'b0; tw_ready = 1'b1; atom = 2'b01; atom_valid = 1'b1; flush = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 128 && cyc < 600) begin
      if (tw_valid && tw_ready) hs++;
      tick();
      cyc++;
    end
    check("halt_frames", 64'(hs), 64'd128);
    check("halt_full", 64'(trc_full), 64'd1);
    check("halt_addr", 64'(tw_addr), 64'd0);
    check("halt_valid", 64'(tw_valid), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("halt_count", 64'(dct_count), 64'd2);
    check("halt_buf", 64'(dct_buffer), 64'h5);
    check("halt_nodrop", 64'(atom_drop), 64'd0);
    check("halt_stays", 64'({trc_full, tw_valid}), 64'b10);
    atom_valid = 1'b0; flush = 1'b0;
    clear();
    check("clr_full", 64'(trc_full), 64'd0);
    check("clr_count", 64'(dct_count), 64'd0);
    check("clr_buf", 64'(dct_buffer), 64'd0);
    check("clr_addr", 64'(tw_addr), 64'd0);

    // Circular mode: the 128th write wraps the address and sets trc_wrap.
    wrap_en = 1'b1; atom_valid = 1'b1; flush = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 128 && cyc < 600) begin
      if (tw_valid && tw_ready) hs++;
      tick();
      cyc++;
    end
    check("wrap_frames", 64'(hs), 64'd128);
    check("wrap_flag", 64'(trc_wrap), 64'd1);
    check("wrap_addr", 64'(tw_addr), 64'd0);
    check("wrap_nofull", 64'(trc_full), 64'd0);
    check("wrap_valid", 64'(tw_valid), 64'd1);

    // Mid-operation reset with a pending frame and seven buffered atoms.
    flush = 1'b0; tw_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_count", 64'(dct_count), 64'd7);
    check("pre_rst_valid", 64'(tw_valid), 64'd1);
    atom_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(tw_valid), 64'd0);
    check("arst_data", 64'(tw_data), 64'd0);
    check("arst_count", 64'({dct_count, dct_buffer}), 64'd0);
    check("arst_flags", 64'({trc_full, trc_wrap, atom_drop}), 64'd0);
    tw_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_addr", 64'(tw_addr), 64'd0);
    check("post_rst_valid", 64'(tw_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
